rtc_timer: RTL and testbench



---
 rtl/rtc_timer.sv | 127 ++++++++++++
 tb/tb_rtc_timer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timer.sv
// rtc_timer: real-time clock core.
//   Keeps a 48-bit seconds / 32-bit nanoseconds / FRAC_W-bit fractional-ns time
//   of day. The time advances by tick_inc_i (unsigned 6.26 ns) every cycle and
//   can be cleared or shifted by a signed offset. Generates a PPS output and
//   timestamps the rising edge of an asynchronous PPS input.
// Ports:
//   rtc_clk, rtc_rst     clock, synchronous active-high reset
//   tick_inc_i           per-cycle increment, 6.26 ns
//   ns_offset_i          signed ns offset, |value| < NS_PER_SEC
//   sc_offset_i          signed seconds offset
//   offset_valid_i       pulse: apply the offsets this cycle
//   clear_rtc_i          pulse: zero the time (wins over offset_valid_i)
//   pps_width_i          PPS output high time, ns
//   pps_i                asynchronous PPS input
//   rtc_std_o/rtc_fns_o  current {sc, ns} and fractional ns
//   pts_std_o/pts_fns_o  time captured at the pps_i rising edge
//   pts_valid_o          one-cycle pulse when pts_* update
//   pps_o                PPS output, aligned with rtc_std_o
module rtc_timer #(
  parameter int NS_PER_SEC = 1_000_000_000,
  parameter int FRAC_W     = 26
) (
  input  logic        rtc_clk,
  input  logic        rtc_rst,
  input  logic [31:0] tick_inc_i,
  input  logic [31:0] ns_offset_i,
  input  logic [47:0] sc_offset_i,
  input  logic        offset_valid_i,
  input  logic        clear_rtc_i,
  input  logic [31:0] pps_width_i,
  input  logic        pps_i,
  output logic [79:0] rtc_std_o,
  output logic [15:0] rtc_fns_o,
  output logic [79:0] pts_std_o,
  output logic [15:0] pts_fns_o,
  output logic        pts_valid_o,
  output logic        pps_o
);

  localparam logic signed [33:0] NS_S = 34'(NS_PER_SEC);

  logic [47:0]        sc_q;
  logic [31:0]        ns_q;
  logic [FRAC_W-1:0]  frac_q;
  logic               pps_q;
  logic [2:0]         pps_sync;   // [0]=s1, [1]=s2, [2]=s3
  logic [79:0]        pts_std_q;
  logic [15:0]        pts_fns_q;
  logic               pts_vld_q;

  logic [FRAC_W:0]    frac_sum;
  logic signed [33:0] ns_sum;
  logic signed [33:0] ns_base;
  logic signed [33:0] ns_fix;
  logic [47:0]        sc_base;
  logic [47:0]        sc_nxt;
  logic [31:0]        ns_nxt;
  logic [FRAC_W-1:0]  frac_nxt;
  logic               pps_rise;

  assign frac_sum = {1'b0, frac_q} + {1'b0, tick_inc_i[FRAC_W-1:0]};
  assign ns_sum   = $signed({2'b00, ns_q}) + $signed(34'(tick_inc_i[31:FRAC_W]))
                  + $signed(34'(frac_sum[FRAC_W]));

  // The tick and the offset share one normalisation step: the offset is
  // simply folded into the base before the wrap check. A plain tick can never
  // go negative, so the underflow branch only fires for offsets.
  always_comb begin
    ns_base  = ns_sum;
    sc_base  = sc_q;
    if (offset_valid_i) begin
      ns_base = ns_sum + $signed({{2{ns_offset_i[31]}}, ns_offset_i});
      sc_base = sc_q + sc_offset_i;
    end
    ns_fix   = ns_base;
    sc_nxt   = sc_base;
    if (ns_base >= NS_S) begin
      ns_fix = ns_base - NS_S;
      sc_nxt = sc_base + 48'd1;
    end else if (ns_base[33]) begin
      ns_fix = ns_base + NS_S;
      sc_nxt = sc_base - 48'd1;
    end
    ns_nxt   = ns_fix[31:0];
    frac_nxt = frac_sum[FRAC_W-1:0];
    if (clear_rtc_i) begin
      sc_nxt   = '0;
      ns_nxt   = '0;
      frac_nxt = '0;
    end
  end

  assign pps_rise = pps_sync[1] & ~pps_sync[2];

  always_ff @(posedge rtc_clk) begin
    if (rtc_rst) begin
      sc_q      <= '0;
      ns_q      <= '0;
      frac_q    <= '0;
      pps_q     <= 1'b0;
      pps_sync  <= '0;
      pts_std_q <= '0;
      pts_fns_q <= '0;
      pts_vld_q <= 1'b0;
    end else begin
      sc_q      <= sc_nxt;
      ns_q      <= ns_nxt;
      frac_q    <= frac_nxt;
      pps_q     <= (ns_nxt < pps_width_i);
      pps_sync  <= {pps_sync[1:0], pps_i};
      pts_vld_q <= pps_rise;
      // Capture takes the registered (pre-update) time, no compensation.
      if (pps_rise) begin
        pts_std_q <= {sc_q, ns_q};
        pts_fns_q <= frac_q[FRAC_W-1 -: 16];
      end
    end
  end

  assign rtc_std_o   = {sc_q, ns_q};
  assign rtc_fns_o   = frac_q[FRAC_W-1 -: 16];
  assign pts_std_o   = pts_std_q;
  assign pts_fns_o   = pts_fns_q;
  assign pts_valid_o = pts_vld_q;
  assign pps_o       = pps_q;

endmodule

// File: tb/tb_rtc_timer.sv
// tb_rtc_timer: directed scenarios plus randomized traffic for rtc_timer,
// every cycle compared against a time-of-day reference model.
module tb_rtc_timer;

  localparam longint NS      = 1000000000;
  localparam longint FR_ONE  = 64'd67108864;          // 2^26
  localparam longint SC_MASK = 64'h0000_FFFF_FFFF_FFFF;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst;
  logic [31:0] tick_inc_i;
  logic [31:0] ns_offset_i;
  logic [47:0] sc_offset_i;
  logic        offset_valid_i;
  logic        clear_rtc_i;
  logic [31:0] pps_width_i;
  logic        pps_i;
  logic [79:0] rtc_std_o;
  logic [15:0] rtc_fns_o;
  logic [79:0] pts_std_o;
  logic [15:0] pts_fns_o;
  logic        pts_valid_o;
  logic        pps_o;

  rtc_timer dut (
    .rtc_clk(rtc_clk), .rtc_rst(rtc_rst), .tick_inc_i(tick_inc_i),
    .ns_offset_i(ns_offset_i), .sc_offset_i(sc_offset_i),
    .offset_valid_i(offset_valid_i), .clear_rtc_i(clear_rtc_i),
    .pps_width_i(pps_width_i), .pps_i(pps_i), .rtc_std_o(rtc_std_o),
    .rtc_fns_o(rtc_fns_o), .pts_std_o(pts_std_o), .pts_fns_o(pts_fns_o),
    .pts_valid_o(pts_valid_o), .pps_o(pps_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: time held as plain integers.
  longint     m_sc, m_ns, m_fr, cyc;
  bit         m_pps, m_pv, prev_p;
  logic [79:0] m_pts_std;
  logic [15:0] m_pts_fns;
  longint     due[$];   // edge numbers at which a capture is due

  function automatic logic [79:0] m_std();
    logic [47:0] s = m_sc[47:0];
    logic [31:0] n = m_ns[31:0];
    return {s, n};
  endfunction

  function automatic logic [15:0] m_fns();
    longint f = m_fr >> 10;
    return f[15:0];
  endfunction

  task automatic model_edge();
    longint tot, adj, sc;
    bit p;
    p = pps_i;
    cyc++;
    if (rtc_rst) begin
      m_sc = 0; m_ns = 0; m_fr = 0; m_pps = 0; m_pv = 0; prev_p = 0;
      m_pts_std = '0; m_pts_fns = '0;
      due.delete();
      return;
    end
    // A synchronous pps rise seen at edge n is captured at edge n+2,
    // using the time held before that edge's update.
    m_pv = 0;
    if (due.size() > 0 && due[0] == cyc) begin
      void'(due.pop_front());
      m_pv = 1;
      m_pts_std = m_std();
      m_pts_fns = m_fns();
    end
    if (p && !prev_p) due.push_back(cyc + 2);
    prev_p = p;

    if (clear_rtc_i) begin
      m_sc = 0; m_ns = 0; m_fr = 0;
    end else begin
      tot  = m_fr + longint'(tick_inc_i[25:0]);
      m_fr = tot % FR_ONE;
      adj  = m_ns + longint'(tick_inc_i[31:26]) + tot / FR_ONE;
      sc   = m_sc;
      if (offset_valid_i) begin
        adj = adj + longint'($signed(ns_offset_i));
        sc  = sc + longint'(sc_offset_i);
      end
      if (adj >= NS) begin
        adj = adj - NS; sc = sc + 1;
      end else if (adj < 0) begin
        adj = adj + NS; sc = sc - 1;
      end
      m_ns = adj;
      m_sc = sc & SC_MASK;
    end
    m_pps = (m_ns < longint'(pps_width_i));
  endtask

  task automatic cyc_step();
    @(posedge rtc_clk);
    model_edge();
    #1;
    chk("rtc_std", rtc_std_o, m_std());
    chk("rtc_fns", rtc_fns_o, m_fns());
    chk("pps_o", pps_o, m_pps);
    chk("pts_valid", pts_valid_o, m_pv);
    chk("pts_std", pts_std_o, m_pts_std);
    chk("pts_fns", pts_fns_o, m_pts_fns);
  endtask

  initial begin
    int hi;
    int npv;
    logic [63:0] r64;
    logic [31:0] r32;
    cyc = 0;
    rtc_rst = 1'b1; tick_inc_i = '0; ns_offset_i = '0; sc_offset_i = '0;
    offset_valid_i = 1'b0; clear_rtc_i = 1'b0; pps_width_i = '0; pps_i = 1'b0;
    repeat (2) cyc_step();
    chk("rst_std", rtc_std_o, 80'd0);
    chk("rst_pts", {pts_valid_o, pts_std_o, pps_o}, 82'd0);

    // 8 ns ticks
    rtc_rst = 1'b0; tick_inc_i = 32'h2000_0000;
    repeat (10) cyc_step();
    chk("t8_std", rtc_std_o, {48'd0, 32'd80});
    chk("t8_fns_pps", {rtc_fns_o, pps_o}, 17'd0);

    // fractional carry
    rtc_rst = 1'b1; cyc_step();
    rtc_rst = 1'b0; tick_inc_i = 32'h1999_9999;
    repeat (5) cyc_step();
    chk("frac_ns31", rtc_std_o, {48'd0, 32'd31});
    chk("frac_fns", rtc_fns_o, 16'hFFFF);
    cyc_step();
    chk("frac_ns38", rtc_std_o, {48'd0, 32'd38});

    // offset to just before a second boundary, then PPS width
    tick_inc_i = 32'h2000_0000; pps_width_i = 32'd100;
    clear_rtc_i = 1'b1; cyc_step(); clear_rtc_i = 1'b0;
    chk("clr_pps", pps_o, 1'b1);
    offset_valid_i = 1'b1; ns_offset_i = 32'd999_999_000; sc_offset_i = '0;
    cyc_step(); offset_valid_i = 1'b0;
    chk("ofs_ns", rtc_std_o, {48'd0, 32'd999_999_008});
    hi = 0;
    repeat (124) begin cyc_step(); hi += int'(pps_o); end
    chk("wrap_std", rtc_std_o, {48'd1, 32'd0});
    repeat (30) begin cyc_step(); hi += int'(pps_o); end
    chk("pps_cnt", hi, 13);

    // offsets: overflow, underflow, negative seconds
    clear_rtc_i = 1'b1; cyc_step(); clear_rtc_i = 1'b0;
    offset_valid_i = 1'b1; ns_offset_i = 32'd999_999_992;
    cyc_step();
    chk("ofs_ovf", rtc_std_o, {48'd1, 32'd0});
    ns_offset_i = 32'hFFFF_FFF0;
    cyc_step();
    chk("ofs_unf", rtc_std_o, {48'd0, 32'd999_999_992});
    tick_inc_i = '0; ns_offset_i = '0; sc_offset_i = 48'hFFFF_FFFF_FFFF;
    cyc_step();
    chk("sc_wrap", rtc_std_o, {48'hFFFF_FFFF_FFFF, 32'd999_999_992});
    offset_valid_i = 1'b0;

    // clear beats offset
    tick_inc_i = 32'h2000_0000;
    clear_rtc_i = 1'b1; cyc_step(); clear_rtc_i = 1'b0;
    offset_valid_i = 1'b1; ns_offset_i = '0; sc_offset_i = 48'd5;
    cyc_step();
    chk("sc5", rtc_std_o[79:32], 48'd5);
    clear_rtc_i = 1'b1; sc_offset_i = 48'd7; ns_offset_i = 32'd12345;
    cyc_step();
    clear_rtc_i = 1'b0; offset_valid_i = 1'b0;
    chk("clr_ofs", {rtc_std_o, rtc_fns_o}, 96'd0);

    // PPS input capture
    clear_rtc_i = 1'b1; cyc_step(); clear_rtc_i = 1'b0;
    repeat (48) cyc_step();
    pps_i = 1'b1;
    cyc_step();   // edge k
    cyc_step();   // edge k+1, ns=400
    chk("pts_early", pts_valid_o, 1'b0);
    cyc_step();   // edge k+2
    chk("pts_pulse", pts_valid_o, 1'b1);
    chk("pts_ns", pts_std_o, {48'd0, 32'd400});
    npv = 0;
    repeat (10) begin cyc_step(); npv += int'(pts_valid_o); end
    chk("pts_hold", npv, 0);
    pps_i = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick_inc_i     = $urandom;
      offset_valid_i = ($urandom_range(0, 15) == 0);
      r32            = $urandom_range(0, 1_999_999_998);
      ns_offset_i    = r32 - 32'd999_999_999;
      r64            = {$urandom, $urandom};
      sc_offset_i    = r64[47:0];
      clear_rtc_i    = ($urandom_range(0, 63) == 0);
      rtc_rst        = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 3))
        0: pps_width_i = '0;
        1: pps_width_i = $urandom_range(0, 999_999_999);
        2: pps_width_i = 32'd1_000_000_000;
        default: pps_width_i = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) pps_i = ~pps_i;
      cyc_step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
